// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Initiator-side memory interface unit for the LC-3b datapath. A load/store
// request from the control FSM is latched into MAR/MDR. The byte-addressed
// 16-bit memory is then driven over a fixed window of WAIT_CYCLES cycles. Load
// data (a word, or a sign-extended byte) is returned with a one-cycle done
// pulse.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : a word access to an odd address skips the memory window and
//               completes at once with err=1, rdata=0 and no write.
//   undefined : err is constant 0 and word accesses are aligned down
//               (MAR[0] forced to 0).
//
// Parameters
//   WAIT_CYCLES  cycles the memory address/data are held per access (>= 1)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   req       in   request strobe, sampled only while ready=1
//   rw        in   1 = store, 0 = load
//   word      in   1 = 16-bit access, 0 = 8-bit access
//   addr      in   [15:0] byte address
//   wdata     in   [15:0] store data (byte stores use wdata[7:0])
//   ready     out  high only in IDLE
//   done      out  one-cycle completion pulse
//   err       out  one-cycle alignment-error pulse, coincident with done
//   rdata     out  [15:0] load result, held until the next completion
//   mem_addr  out  [15:0] memory address (MAR)
//   mem_din   out  [15:0] memory write data (MDR)
//   mem_we    out  memory write enable
//   mem_word  out  memory word/byte select (1 = word)
//   mem_dout  in   [15:0] memory read data ([7:0] = byte at address)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic        word,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  output logic        mem_word,
  input  logic [15:0] mem_dout
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      mar;
  logic [15:0]      mdr;
  logic             rw_q;
  logic             word_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_access;
  logic             misalign;
  logic [15:0]      mar_in;

  // LDB semantics: the addressed byte always arrives on mem_dout[7:0]
  // whatever the address parity, so sign extension works from bit 7.
  function automatic logic [15:0] load_result(input logic       is_word,
                                              input logic [15:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] bx;
    b  = d[7:0];
    bx = 16'(b);
    return is_word ? d : bx;
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = word & addr[0];
  assign mar_in   = addr;
`else
  assign misalign = 1'b0;
  assign mar_in   = word ? {addr[15:1], 1'b0} : addr;
`endif

  assign accept      = (state == IDLE) && req;
  assign last_access = (state == ACCESS) && (cnt == '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = misalign ? DONE : ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; mem_we is combinational so a store whose write cycle
  // coincides with reset is still presented to memory that cycle.
  always_comb begin
    ready  = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    mem_we = 1'b0;
    case (state)
      IDLE:   ready  = 1'b1;
      ACCESS: mem_we = last_access & rw_q;
      DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ready = 1'b0;
    endcase
  end

  // Request latch, wait counter and load capture
  always_ff @(posedge clk) begin
    if (reset) begin
      mar    <= '0;
      mdr    <= '0;
      rw_q   <= 1'b0;
      word_q <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
      rdata  <= '0;
    end else if (accept) begin
      mar    <= mar_in;
      mdr    <= wdata;
      rw_q   <= rw;
      word_q <= word;
      err_q  <= misalign;
      cnt    <= CNT_LOAD;
      if (misalign) rdata <= '0;
    end else if (state == ACCESS) begin
      if (cnt != '0)  cnt   <= cnt - 1'b1;
      else if (!rw_q) rdata <= load_result(word_q, mem_dout);
    end
  end

  assign mem_addr = mar;
  assign mem_din  = mdr;
  assign mem_word = word_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int WAIT = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic        word = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        ready, done, err, mem_we, mem_word;
  logic [15:0] rdata, mem_addr, mem_din, mem_dout;

  mem_access_ctrl #(.WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .word(word),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_word(mem_word), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-addressed memory model
  logic [7:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  assign mem_dout = {mem[mem_addr + 16'd1], mem[mem_addr]};
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_din[7:0];
      if (mem_word) mem[mem_addr + 16'd1] <= mem_din[15:8];
    end
  end

  typedef struct {int cyc; logic err; logic [15:0] rdata;} done_t;
  typedef struct {int cyc; logic [15:0] addr; logic [15:0] din; logic word;} wr_t;
  done_t done_q[$];
  wr_t   wr_q[$];

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] last_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares completions and memory writes against the scoreboard
  always @(negedge clk) begin
    done_t de;
    wr_t   we;
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, none expected", cyc);
      end else begin
        de = done_q.pop_front();
        chk("done_cycle", cyc, de.cyc);
        chk("err", {31'b0, err}, {31'b0, de.err});
        chk("rdata", {16'b0, rdata}, {16'b0, de.rdata});
      end
    end
    if (mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_we: mem_we=1 at cycle %0d addr %0h, none expected", cyc, mem_addr);
      end else begin
        we = wr_q.pop_front();
        chk("we_cycle", cyc, we.cyc);
        chk("we_addr", {16'b0, mem_addr}, {16'b0, we.addr});
        chk("we_din", {16'b0, mem_din}, {16'b0, we.din});
        chk("we_word", {31'b0, mem_word}, {31'b0, we.word});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: ready=%b after 50 cycles, required 1", ready);
    end
  endtask

  // Issues one request and pushes its expected write / completion.
  task automatic do_req(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_load);
    int  n;
    logic mis;
    logic [15:0] a_al;
    wait_ready();
    req = 1'b1; rw = r; word = w; addr = a; wdata = d;
    n = cyc;
    mis = CHK_EN && w && a[0];
    a_al = (w && !CHK_EN) ? (a & 16'hFFFE) : a;
    if (mis) begin
      last_rdata = 16'h0000;
      done_q.push_back('{n + 1, 1'b1, 16'h0000});
    end else begin
      if (r) wr_q.push_back('{n + WAIT, a_al, d, w});
      else   last_rdata = exp_load;
      done_q.push_back('{n + WAIT + 1, 1'b0, last_rdata});
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},    {31'b0, ready},    32'd1);
    chk({tag, "_done"},     {31'b0, done},     32'd0);
    chk({tag, "_err"},      {31'b0, err},      32'd0);
    chk({tag, "_rdata"},    {16'b0, rdata},    32'd0);
    chk({tag, "_mem_addr"}, {16'b0, mem_addr}, 32'd0);
    chk({tag, "_mem_din"},  {16'b0, mem_din},  32'd0);
    chk({tag, "_mem_we"},   {31'b0, mem_we},   32'd0);
    chk({tag, "_mem_word"}, {31'b0, mem_word}, 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    // Word store then load
    do_req(1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h0);
    do_req(1'b0, 1'b1, 16'h0040, 16'h0000, 16'hBEEF);

    // Byte stores to both parities, word readback
    do_req(1'b1, 1'b0, 16'h0050, 16'h0012, 16'h0);
    do_req(1'b1, 1'b0, 16'h0051, 16'h0034, 16'h0);
    do_req(1'b0, 1'b1, 16'h0050, 16'h0000, 16'h3412);

    // Byte load sign extension (upper store bits must be ignored)
    do_req(1'b1, 1'b0, 16'h0051, 16'hAA80, 16'h0);
    do_req(1'b0, 1'b0, 16'h0051, 16'h0000, 16'hFF80);
    do_req(1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0012);
    do_req(1'b1, 1'b0, 16'h0051, 16'h007F, 16'h0);
    do_req(1'b0, 1'b0, 16'h0051, 16'h0000, 16'h007F);

    // Busy ignore: req held high with a store through ACCESS and DONE
    do_req(1'b0, 1'b1, 16'h0040, 16'h0000, 16'hBEEF);
    req = 1'b1; rw = 1'b1; word = 1'b1; addr = 16'h0070; wdata = 16'hDEAD;
    repeat (5) @(negedge clk);
    req = 1'b0;

    // Reset mid-access of a store: no write, no done
    do_req(1'b1, 1'b1, 16'h0060, 16'h1111, 16'h0);
    wait_ready();
    req = 1'b1; rw = 1'b1; word = 1'b1; addr = 16'h0060; wdata = 16'h5555;
    n = cyc;
    @(negedge clk); req = 1'b0;
    @(negedge clk); reset = 1'b1;
    chk("abort_cycle", cyc, n + 2);
    @(negedge clk); reset = 1'b0;
    chk_reset_vals("abort");
    last_rdata = 16'h0000;
    repeat (8) @(negedge clk);
    do_req(1'b0, 1'b1, 16'h0060, 16'h0000, 16'h1111);

    // Reset and req together: reset wins
    wait_ready();
    reset = 1'b1; req = 1'b1; rw = 1'b1; word = 1'b1; addr = 16'h0062; wdata = 16'h7777;
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    last_rdata = 16'h0000;
    chk("rst_req_ready", {31'b0, ready}, 32'd1);
    repeat (8) @(negedge clk);
    do_req(1'b0, 1'b1, 16'h0062, 16'h0000, 16'h0000);

    // Misaligned word store
    do_req(1'b1, 1'b1, 16'h0041, 16'h1234, 16'h0);
    do_req(1'b0, 1'b1, 16'h0040, 16'h0000, CHK_EN ? 16'hBEEF : 16'h1234);

    // Drain
    n = 0;
    while ((done_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("done_q_empty", done_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side memory interface unit for the LC-3b datapath. It accepts load/store requests from the control FSM, latches the address and store data into MAR/MDR, and drives the byte-addressed 16-bit memory (address, din, WE, word/byte select) over a fixed multi-cycle access window. On completion it returns load data (word, or sign-extended byte) with a one-cycle done pulse. It sits between the datapath/control FSM and the memory array.

## Interface
- WAIT_CYCLES, 4, cycles the memory address/data are held before completion; legal range ≥1.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; returns the block to IDLE on the next rising edge.
- req  input  1  request strobe; sampled only when ready=1.
- rw  input  1  1 = store, 0 = load.
- word  input  1  1 = 16-bit access, 0 = 8-bit access (drives memory mdrControl).
- addr  input  16  byte address.
- wdata  input  16  store data; byte stores use wdata[7:0].
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle alignment-error pulse, coincident with done.
- rdata  output  16  load result, valid while done=1, held until next done.
- mem_addr  output  16  memory address (MAR).
- mem_din  output  16  memory write data (MDR).
- mem_we  output  1  memory write enable.
- mem_word  output  1  memory word/byte select (1 = word).
- mem_dout  input  16  memory read data; dout[7:0]=byte at address, dout[15:8]=byte at address+1.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: ready=1. If req=1, latch addr→MAR, wdata→MDR, rw, word; load counter with WAIT_CYCLES-1; go ACCESS. req with ready=0 is ignored, not queued.
- ACCESS: mem_addr=MAR, mem_din=MDR, mem_word=latched word, held constant. Counter decrements each cycle. On the cycle counter==0 (last ACCESS cycle): for stores assert mem_we for exactly that cycle; for loads capture rdata. Go DONE.
- Load result: word → mem_dout[15:0]; byte → {8{mem_dout[7]}, mem_dout[7:0]} (LDB sign-extend, either address parity).
- Store: word writes both bytes at MAR (even); byte writes wdata[7:0] at MAR exactly (even or odd).
- DONE: done=1 (err=1 if flagged); go IDLE next cycle. rdata is not modified by stores.
- mem_we is never high outside the last ACCESS cycle; never high for an errored request.

## Timing
- Request accepted at cycle N → ACCESS cycles N+1..N+WAIT_CYCLES → mem_we (store) at N+WAIT_CYCLES → done at N+WAIT_CYCLES+1 → ready at N+WAIT_CYCLES+2.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- Reset values: state IDLE, ready=1, done=0, err=0, rdata=0, mem_addr=0, mem_din=0, mem_we=0, mem_word=0, counter=0.
- Reset during ACCESS/DONE: next edge returns to IDLE with reset values; an in-flight store whose mem_we cycle coincides with reset is still presented to memory that cycle but no done is produced; no subsequent mem_we.
- reset and req in the same cycle: reset wins, request dropped.

## Configuration
- MEM_ALIGN_CHECK_EN defined: a word access with addr[0]=1 skips ACCESS; goes IDLE→DONE directly (done at N+1) with err=1, rdata=0, no mem_we, MAR/MDR still latched.
- Undefined: no check, err tied 0; word accesses force MAR[0]=0 (aligned down) and proceed normally.

## Test plan
- Word store then load, WAIT_CYCLES=4: store 0xBEEF @0x0040 → mem_we high only at cycle N+4 with mem_addr=0x0040, mem_word=1; done at N+5; load @0x0040 → rdata=0xBEEF.
- Byte stores: store 0x0012 @0x0050 and 0x0034 @0x0051 (word=0) → word load @0x0050 returns 0x3412.
- Byte load sign-extend: memory 0x80 @0x0051 → byte load @0x0051 → rdata=0xFF80; 0x7F → 0x007F.
- Busy ignore: req pulsed every cycle during an access → exactly one done per WAIT_CYCLES+2 cycles; no extra mem_we.
- Reset mid-access: assert reset at N+2 of a store → no mem_we, no done, ready=1 and all outputs at reset values after the edge.
- Misaligned word store @0x0041: with MEM_ALIGN_CHECK_EN → done=err=1 at N+1, no mem_we; without → write lands at 0x0040, err=0.
